// File: rtl/servo_pkg.sv
// Shared constants and types for the servo pulse generator.
package servo_pkg;

    localparam int         DEF_CLK_HZ       = 12_000_000;
    localparam logic [9:0] DEF_MIN_POS      = 10'd228;
    localparam logic [9:0] DEF_MAX_POS      = 10'd830;
    localparam int         DEF_PULSE_MIN_US = 1000;
    localparam int         DEF_PULSE_MAX_US = 2000;
    localparam int         DEF_FRAME_US     = 20000;
    localparam int         DEF_SLEW_US      = 100;

    // Pulse width in microseconds
    typedef logic [10:0] width_t;

    localparam width_t CENTER_US = 11'd1500;

    // Clamp a full 32-bit position into [lo, hi]; the compare uses all 32 bits
    function automatic logic [9:0] clamp_pos(input logic [31:0] pos,
                                             input logic [9:0]  lo,
                                             input logic [9:0]  hi);
        if (pos < {22'd0, lo}) return lo;
        if (pos > {22'd0, hi}) return hi;
        return pos[9:0];
    endfunction

endpackage

// File: rtl/pos_to_width.sv
// Clamps a sampled position and maps it to a pulse width with a
// 20-iteration restoring divider. done is high for one cycle, 21 cycles
// after start, while width holds the result.
module pos_to_width
    import servo_pkg::*;
#(
    parameter logic [9:0] MIN_POS      = DEF_MIN_POS,
    parameter logic [9:0] MAX_POS      = DEF_MAX_POS,
    parameter int         PULSE_MIN_US = DEF_PULSE_MIN_US,
    parameter int         PULSE_MAX_US = DEF_PULSE_MAX_US
) (
    input  logic        CLK,
    input  logic        SW1,
    input  logic        start,
    input  logic [31:0] pos,
    output width_t      width,
    output logic        done
);

    localparam logic [19:0] SPAN    = 20'(PULSE_MAX_US - PULSE_MIN_US);
    localparam logic [10:0] DIVISOR = 11'(MAX_POS - MIN_POS);
    localparam logic [4:0]  LAST_IT = 5'd19;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    div_state_t  state_q;
    logic [19:0] quo_q;
    logic [9:0]  rem_q;
    logic [4:0]  cnt_q;

    logic [9:0]  pos_c;
    logic [19:0] prod;
    logic [10:0] trial;
    logic [9:0]  rem_d;
    logic        bit_d;

    // Clamp the position and form the 20-bit dividend
    always_comb begin
        pos_c = clamp_pos(pos, MIN_POS, MAX_POS);
        prod  = 20'(pos_c - MIN_POS) * SPAN;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial = {rem_q, quo_q[19]};
        if (trial >= DIVISOR) begin
            rem_d = 10'(trial - DIVISOR);
            bit_d = 1'b1;
        end else begin
            rem_d = trial[9:0];
            bit_d = 1'b0;
        end
    end

    // Divider sequencing: load on start, 20 shift/subtract steps, one DONE cycle
    always_ff @(posedge CLK or posedge SW1) begin
        if (SW1) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    quo_q   <= prod;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    quo_q <= {quo_q[18:0], bit_d};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_IT) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Quotient is below 2^11 by construction, so the low bits carry it
    assign width = width_t'(PULSE_MIN_US) + quo_q[10:0];
    assign done  = (state_q == DONE);

endmodule

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: fixed frame, pulse width mapped from the
// position sampled at each frame start, applied one frame later.
// Optional feature macro: SERVO_SLEW_LIMIT_EN limits the width change per
// frame to SLEW_US.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int         CLK_HZ       = DEF_CLK_HZ,
    parameter logic [9:0] MIN_POS      = DEF_MIN_POS,
    parameter logic [9:0] MAX_POS      = DEF_MAX_POS,
    parameter int         PULSE_MIN_US = DEF_PULSE_MIN_US,
    parameter int         PULSE_MAX_US = DEF_PULSE_MAX_US,
    parameter int         FRAME_US     = DEF_FRAME_US,
    parameter int         SLEW_US      = DEF_SLEW_US
) (
    input  logic        CLK,
    input  logic        SW1,
    input  logic [31:0] i_pos,
    output logic        o_pwm,
    output logic        o_frame_start,
    output logic [10:0] o_width_us
);

    localparam int DIV   = CLK_HZ / 1_000_000;
    localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int US_W  = $clog2(FRAME_US);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [US_W-1:0]  us_cnt_q, us_cnt_d;
    width_t           width_q, width_d;
    width_t           width_next_q, width_next_d;
    width_t           div_width;
    logic             div_done;
    logic             pwm_q, pwm_d;
    logic             fs_q;
    logic             tick, frame_start;

    pos_to_width #(
        .MIN_POS      (MIN_POS),
        .MAX_POS      (MAX_POS),
        .PULSE_MIN_US (PULSE_MIN_US),
        .PULSE_MAX_US (PULSE_MAX_US)
    ) u_map (
        .CLK   (CLK),
        .SW1   (SW1),
        .start (frame_start),
        .pos   (i_pos),
        .width (div_width),
        .done  (div_done)
    );

    // Microsecond prescaler and frame counter; the wrap tick starts a frame
    always_comb begin
        tick        = (psc_q == PSC_LAST);
        frame_start = tick && (us_cnt_q == US_LAST);
        psc_d       = tick ? '0 : psc_q + 1'b1;
        us_cnt_d    = us_cnt_q;
        if (frame_start)  us_cnt_d = '0;
        else if (tick)    us_cnt_d = us_cnt_q + 1'b1;
    end

    // Width register only moves at frame start; pulse compares against it
    always_comb begin
        width_next_d = div_done ? div_width : width_next_q;
        width_d      = width_q;
        if (frame_start) begin
`ifdef SERVO_SLEW_LIMIT_EN
            if ({1'b0, width_next_q} > {1'b0, width_q} + 12'(SLEW_US))
                width_d = width_q + 11'(SLEW_US);
            else if ({1'b0, width_next_q} + 12'(SLEW_US) < {1'b0, width_q})
                width_d = width_q - 11'(SLEW_US);
            else
                width_d = width_next_q;
`else
            width_d = width_next_q;
`endif
        end
        pwm_d = (32'(us_cnt_q) < 32'(width_q));
    end

    // State and output registers; reset clears the pin immediately
    always_ff @(posedge CLK or posedge SW1) begin
        if (SW1) begin
            psc_q        <= '0;
            us_cnt_q     <= '0;
            width_q      <= CENTER_US;
            width_next_q <= CENTER_US;
            pwm_q        <= 1'b0;
            fs_q         <= 1'b0;
        end else begin
            psc_q        <= psc_d;
            us_cnt_q     <= us_cnt_d;
            width_q      <= width_d;
            width_next_q <= width_next_d;
            pwm_q        <= pwm_d;
            fs_q         <= frame_start;
        end
    end

    assign o_pwm         = pwm_q;
    assign o_frame_start = fs_q;
    assign o_width_us    = width_q;

endmodule
